// File: rtl/disp_pkg.sv
// Shared definitions for the threshold display: segment codes,
// the default digit count and the converter state encoding.
package disp_pkg;

    localparam int DEF_NUM_DIGITS = 4;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } conv_state_t;

    // Decimal nibble to segment pattern; non-decimal nibbles go dark
    function automatic logic [6:0] seg_encode(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bin2bcd_dd.sv
// Sequential double-dabble binary-to-BCD converter.
// One add-3/shift iteration per clock; o_bcd only changes when a
// conversion fully completes, so an aborted run never leaks out.
// o_busy covers LOAD and SHIFT; o_done is high for the DONE cycle.
module bin2bcd_dd
    import disp_pkg::*;
#(
    parameter int THRESH_W   = 12,
    parameter int NUM_DIGITS = DEF_NUM_DIGITS
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    input  logic [THRESH_W-1:0]     i_bin,
    output logic [4*NUM_DIGITS-1:0] o_bcd,
    output logic                    o_busy,
    output logic                    o_done
);

    localparam int BCD_W  = 4 * NUM_DIGITS;
    localparam int ITER_W = (THRESH_W > 1) ? $clog2(THRESH_W) : 1;

    conv_state_t          state, state_nxt;
    logic [THRESH_W-1:0]  sh;
    logic [BCD_W-1:0]     scr;
    logic [BCD_W-1:0]     scr_adj;
    logic [ITER_W-1:0]    iter;
    logic                 last_iter;

    assign last_iter = (iter == ITER_W'(THRESH_W - 1));

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next-state and status outputs
    always_comb begin
        state_nxt = state;
        o_busy    = 1'b0;
        o_done    = 1'b0;
        case (state)
            ST_IDLE:  if (i_start) state_nxt = ST_LOAD;
            ST_LOAD: begin
                o_busy    = 1'b1;
                state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                o_busy = 1'b1;
                if (last_iter) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                o_done    = 1'b1;
                state_nxt = ST_IDLE;
            end
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Add-3 correction on every nibble that would overflow past 9 when doubled
    always_comb begin
        scr_adj = scr;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (scr[4*d +: 4] >= 4'd5) scr_adj[4*d +: 4] = scr[4*d +: 4] + 4'd3;
        end
    end

    // Shift datapath and result register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sh    <= '0;
            scr   <= '0;
            iter  <= '0;
            o_bcd <= '0;
        end else begin
            case (state)
                ST_LOAD: begin
                    sh   <= i_bin;
                    scr  <= '0;
                    iter <= '0;
                end
                ST_SHIFT: begin
                    scr  <= {scr_adj[BCD_W-2:0], sh[THRESH_W-1]};
                    sh   <= {sh[THRESH_W-2:0], 1'b0};
                    iter <= iter + 1'b1;
                end
                ST_DONE:  o_bcd <= scr;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/sobel_thresh_display.sv
// Threshold readout on a 4-digit common-anode seven-segment display.
// Watches i_value, converts it to BCD whenever it differs from the last
// converted value, and scans the digits one at a time.
// Optional build macro DISP_LZ_BLANK_EN: blank leading zero digits
// (the ones digit always stays lit). Anode scanning is unaffected.
// NUM_DIGITS must satisfy 10^NUM_DIGITS > 2^THRESH_W.
module sobel_thresh_display
    import disp_pkg::*;
#(
    parameter int THRESH_W    = 12,
    parameter int NUM_DIGITS  = DEF_NUM_DIGITS,
    parameter int REFRESH_DIV = 100_000
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [THRESH_W-1:0]     i_value,
    output logic [4*NUM_DIGITS-1:0] o_bcd,
    output logic                    o_busy,
    output logic [NUM_DIGITS-1:0]   o_an,
    output logic [6:0]              o_seg
);

    localparam int SCAN_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [THRESH_W-1:0]   last_val;
    logic                  start;
    logic                  conv_busy;
    logic                  conv_done;
    logic [SCAN_W-1:0]     scan_cnt;
    logic [IDX_W-1:0]      idx;
    logic [NUM_DIGITS-1:0] lz;
    logic [3:0]            cur_digit;
    logic                  cur_blank;

    // Busy spans the whole conversion including the result-commit cycle,
    // so a new start is only considered once the converter is back in IDLE.
    assign o_busy = conv_busy | conv_done;
    assign start  = !o_busy && (i_value != last_val);

    // Latch the value being converted; the converter loads it the next cycle,
    // so later input changes cannot corrupt the run in progress.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)      last_val <= '0;
        else if (start) last_val <= i_value;
    end

    bin2bcd_dd #(
        .THRESH_W   (THRESH_W),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_conv (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_start (start),
        .i_bin   (last_val),
        .o_bcd   (o_bcd),
        .o_busy  (conv_busy),
        .o_done  (conv_done)
    );

    // Refresh prescaler and digit index
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            scan_cnt <= '0;
            idx      <= '0;
        end else if (scan_cnt == SCAN_W'(REFRESH_DIV - 1)) begin
            scan_cnt <= '0;
            idx      <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    // Leading-zero mask, walked from the most-significant digit downward
    always_comb begin
        logic run;
        lz  = '0;
        run = 1'b1;
`ifdef DISP_LZ_BLANK_EN
        for (int d = NUM_DIGITS - 1; d >= 1; d--) begin
            run   = run && (o_bcd[4*d +: 4] == 4'd0);
            lz[d] = run;
        end
`else
        run = 1'b0;
`endif
    end

    // Select the nibble and blank flag for the digit being scanned
    always_comb begin
        cur_digit = '0;
        cur_blank = 1'b0;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (idx == IDX_W'(d)) begin
                cur_digit = o_bcd[4*d +: 4];
                cur_blank = lz[d];
            end
        end
    end

    // Anode and segment outputs share one register stage so they switch together
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_an  <= '1;
            o_seg <= SEG_BLANK;
        end else begin
            o_an  <= ~(NUM_DIGITS'(1) << idx);
            o_seg <= cur_blank ? SEG_BLANK : seg_encode(cur_digit);
        end
    end

endmodule

// File: tb/tb_sobel_thresh_display.sv
// Directed bench for sobel_thresh_display with a short refresh period.
// Expected segment images follow DISP_LZ_BLANK_EN when it is defined.
module tb_sobel_thresh_display;

    localparam int TW = 12;
    localparam int ND = 4;
    localparam int RD = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [TW-1:0]   value;
    logic [4*ND-1:0] bcd;
    logic            busy;
    logic [ND-1:0]   an;
    logic [6:0]      seg;

    int n_vec = 0;
    int n_err = 0;
    int n;

    sobel_thresh_display #(
        .THRESH_W    (TW),
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (RD)
    ) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_value (value),
        .o_bcd   (bcd),
        .o_busy  (busy),
        .o_an    (an),
        .o_seg   (seg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Wait for a conversion to start (if not already) and count its busy cycles
    task automatic conv_wait(output int cycles);
        int t;
        cycles = 0;
        t = 0;
        while (!busy && t < 8) begin
            @(negedge clk);
            t++;
        end
        while (busy && cycles < 100) begin
            @(negedge clk);
            cycles++;
        end
        if (busy) chk("busy_timeout", 32'(busy), 32'd0);
    endtask

    // Align to the ones-digit slot, then check every cycle of one full scan.
    // exp_segs packs {digit3, digit2, digit1, digit0}.
    task automatic check_scan(input string tag, input logic [27:0] exp_segs);
        logic [ND-1:0] prev;
        logic [ND-1:0] exp_an;
        bit found;
        found = 1'b0;
        for (int t = 0; t < 4 * ND * RD + 4 && !found; t++) begin
            prev = an;
            @(negedge clk);
            if (an == 4'b1110 && prev != 4'b1110) found = 1'b1;
        end
        chk({tag, "_align"}, 32'(found), 32'd1);
        if (found) begin
            for (int d = 0; d < ND; d++) begin
                exp_an = ~(4'b0001 << d);
                for (int k = 0; k < RD; k++) begin
                    chk({tag, "_an"},  32'(an),  32'(exp_an));
                    chk({tag, "_seg"}, 32'(seg), 32'(exp_segs[7*d +: 7]));
                    @(negedge clk);
                end
            end
        end
    endtask

    initial begin
        rst   = 1'b1;
        value = '0;
        repeat (3) @(negedge clk);
        chk("rst_bcd",  32'(bcd),  32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_an",   32'(an),   32'hF);
        chk("rst_seg",  32'(seg),  32'h7F);
        rst = 1'b0;

        // Value 0 right after reset: matches last-converted, nothing starts
        n = 0;
        repeat (20) begin
            @(negedge clk);
            n += int'(busy);
        end
        chk("zero_nobusy", 32'(n), 32'd0);
        chk("zero_bcd", 32'(bcd), 32'h0);
`ifdef DISP_LZ_BLANK_EN
        check_scan("zero", {7'h7F, 7'h7F, 7'h7F, 7'h40});
`else
        check_scan("zero", {7'h40, 7'h40, 7'h40, 7'h40});
`endif

        // Full-scale value: busy for LOAD + 12 SHIFT + DONE
        value = 12'd4095;
        conv_wait(n);
        chk("max_busylen", 32'(n), 32'd14);
        chk("max_bcd", 32'(bcd), 32'h4095);
        chk("max_busy", 32'(busy), 32'h0);

        value = 12'd1234;
        conv_wait(n);
        chk("v1234_bcd", 32'(bcd), 32'h1234);
        check_scan("v1234", {7'h79, 7'h24, 7'h30, 7'h19});

        value = 12'd200;
        conv_wait(n);
        chk("v200_bcd", 32'(bcd), 32'h0200);
`ifdef DISP_LZ_BLANK_EN
        check_scan("v200", {7'h7F, 7'h24, 7'h40, 7'h40});
`else
        check_scan("v200", {7'h40, 7'h24, 7'h40, 7'h40});
`endif

        // Input changes on the 5th SHIFT cycle: first run finishes, then restarts
        value = 12'd1000;
        repeat (6) @(negedge clk);
        chk("chg_busy_mid", 32'(busy), 32'h1);
        value = 12'd3800;
        conv_wait(n);
        chk("chg_first_bcd", 32'(bcd), 32'h1000);
        conv_wait(n);
        chk("chg_second_len", 32'(n), 32'd14);
        chk("chg_second_bcd", 32'(bcd), 32'h3800);

        // Reset on the 6th SHIFT cycle aborts cleanly, then conversion restarts
        value = 12'd4095;
        repeat (7) @(negedge clk);
        chk("abort_busy_pre", 32'(busy), 32'h1);
        rst = 1'b1;
        #1;
        chk("abort_bcd",  32'(bcd),  32'h0);
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_an",   32'(an),   32'hF);
        chk("abort_seg",  32'(seg),  32'h7F);
        @(negedge clk);
        rst = 1'b0;
        conv_wait(n);
        chk("restart_len", 32'(n), 32'd14);
        chk("restart_bcd", 32'(bcd), 32'h4095);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
